// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and default lengths for the unary adder datapath
package unary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int MAX_LEN_DEF      = 19;
    localparam int WRITE_CYCLES_DEF = 20;

endpackage

// File: rtl/unary_operand_sequencer_if.sv
// rtl/unary_operand_sequencer_if.sv - operand-pair valid/ready handshake bundle
interface unary_operand_sequencer_if #(
    parameter int CNT_W = 5
);

    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] a_val;
    logic [CNT_W-1:0] b_val;

    modport master (output in_valid, output a_val, output b_val, input in_ready);
    modport slave  (input in_valid, input a_val, input b_val, output in_ready);

endinterface

// File: rtl/unary_therm_gen.sv
// rtl/unary_therm_gen.sv - stream index counter with per-lane thermometer compare
module unary_therm_gen #(
    parameter int MAX_LEN = 19,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [CNT_W-1:0] a_lim,
    input  logic [CNT_W-1:0] b_lim,
    output logic             a_bit,
    output logic             b_bit,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;

    // Next index: clear wins over advance; otherwise hold the current bit position
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (adv) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // Index register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Ones-first streams: a lane is high while the index is below its operand
    assign a_bit = (idx_q < a_lim);
    assign b_bit = (idx_q < b_lim);
    assign last  = (idx_q == LAST_IDX);

endmodule

// File: rtl/unary_operand_sequencer.sv
// rtl/unary_operand_sequencer.sv - feeds binary operand pairs to the unary adder as thermometer streams
module unary_operand_sequencer
    import unary_pkg::*;
#(
    parameter int MAX_LEN      = MAX_LEN_DEF,
    parameter int WRITE_CYCLES = WRITE_CYCLES_DEF,
    parameter int CNT_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    unary_operand_sequencer_if.slave    up,
    input  logic                        hold,
    output logic                        A,
    output logic                        B,
    output logic                        en,
    output logic                        read_or_write,
    output logic                        sat,
    output logic                        busy,
    output logic                        done
);

    localparam int               WC_W    = $clog2(WRITE_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_LEN);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WRITE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] a_q, a_d;
    logic [CNT_W-1:0] b_q, b_d;
    logic             sat_q, sat_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             idx_clr, idx_adv, idx_last;
    logic             a_bit, b_bit;

    unary_therm_gen #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_therm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (idx_clr),
        .adv   (idx_adv),
        .a_lim (a_q),
        .b_lim (b_q),
        .a_bit (a_bit),
        .b_bit (b_bit),
        .last  (idx_last)
    );

    // Next-state: accept and clamp in IDLE, step the stream unless held, time the write phase
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        wcnt_d  = wcnt_q;
        idx_clr = 1'b0;
        idx_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up.in_valid) begin
                    a_d     = (up.a_val > MAX_V) ? MAX_V : up.a_val;
                    b_d     = (up.b_val > MAX_V) ? MAX_V : up.b_val;
                    sat_d   = (up.a_val > MAX_V) || (up.b_val > MAX_V);
                    idx_clr = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A held last bit is reissued, so the exit waits for a non-held cycle
                if (!hold) begin
                    if (idx_last) begin
                        idx_clr = 1'b1;
                        wcnt_d  = '0;
                        state_d = ST_WRITE;
                    end else begin
                        idx_adv = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                wcnt_d = wcnt_q + WC_W'(1);
                if (wcnt_q == WC_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers; reset aborts any transaction back to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Output decode from registered state; hold only masks the current stream cycle
    always_comb begin
        A             = 1'b0;
        B             = 1'b0;
        en            = 1'b0;
        read_or_write = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_STREAM: begin
                en = !hold;
                A  = a_bit && !hold;
                B  = b_bit && !hold;
            end
            ST_WRITE: begin
                en            = 1'b1;
                read_or_write = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        up.in_ready = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        sat         = sat_q;
    end

endmodule

// File: tb/tb_unary_operand_sequencer.sv
// tb/tb_unary_operand_sequencer.sv - directed self-checking bench for unary_operand_sequencer
module tb_unary_operand_sequencer;

    localparam int ML = 19;
    localparam int WC = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hold  = 1'b0;
    logic A, B, en, rw, sat, busy, done;

    int checks   = 0;
    int failures = 0;

    unary_operand_sequencer_if #(.CNT_W(5)) up_if ();

    unary_operand_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up            (up_if),
        .hold          (hold),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (rw),
        .sat           (sat),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair in IDLE and follow the transaction to the cycle after done.
    // hs/hl: stall while 'hs' bits have been issued, for 'hl' cycles (hs<0 = no hold).
    task automatic run_txn(input int a, input int b, input int hs, input int hl, input int exp_sat);
        int ea, eb, cyc, issued, held, rd, wr, bad, a1, b1, done_cyc;
        bit done_seen;
        ea = (a > ML) ? ML : a;
        eb = (b > ML) ? ML : b;
        issued = 0; held = 0; rd = 0; wr = 0; bad = 0; a1 = 0; b1 = 0;
        done_cyc = -1; done_seen = 0;
        check_val("in_ready_idle", up_if.in_ready, 1);
        up_if.in_valid = 1'b1;
        up_if.a_val    = 5'(a);
        up_if.b_val    = 5'(b);
        tick();
        up_if.in_valid = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 200) begin
            hold = (issued == hs) && (held < hl);
            #1;
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                check_val("busy_in_done", busy, 1);
            end else if (rw) begin
                wr++;
                if (!en || A || B) bad++;
            end else begin
                rd++;
                if (rd == 1) check_val("sat_latched", sat, exp_sat);
                if (hold) begin
                    held++;
                    if (en || A || B) bad++;
                end else begin
                    if (!en || (A != (issued < ea)) || (B != (issued < eb))) bad++;
                    a1 += A;
                    b1 += B;
                    issued++;
                end
            end
            @(posedge clk);
            #1;
            hold = 1'b0;
            cyc++;
        end
        if (!done_seen) check_val("done_timeout", 0, 1);
        check_val("a_ones", a1, ea);
        check_val("b_ones", b1, eb);
        check_val("read_len", rd, ML + hl);
        check_val("write_len", wr, WC);
        check_val("stream_bits_bad", bad, 0);
        check_val("done_cycle", done_cyc, ML + hl + WC + 1);
        check_val("idle_in_ready", up_if.in_ready, 1);
        check_val("idle_busy", busy, 0);
        check_val("idle_done", done, 0);
        check_val("sat_held", sat, exp_sat);
    endtask

    initial begin
        int acc_n, acc2_c, done_c, n;
        up_if.in_valid = 1'b0;
        up_if.a_val    = '0;
        up_if.b_val    = '0;

        // reset state
        rst_n = 1'b0;
        up_if.in_valid = 1'b1;
        tick();
        tick();
        up_if.in_valid = 1'b0;
        check_val("rst_in_ready", up_if.in_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_en", en, 0);
        check_val("rst_AB", {30'd0, A, B}, 0);
        check_val("rst_rw", rw, 0);
        check_val("rst_sat", sat, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        run_txn(3, 3, -1, 0, 0);
        run_txn(0, 19, -1, 0, 0);
        run_txn(25, 2, -1, 0, 1);
        run_txn(5, 1, 2, 3, 0);
        run_txn(19, 0, 18, 1, 0);

        // reset in the middle of STREAM at idx=10
        up_if.in_valid = 1'b1;
        up_if.a_val    = 5'd7;
        up_if.b_val    = 5'd12;
        tick();
        up_if.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_val("pre_abort_en", en, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("abort_AB", {30'd0, A, B}, 0);
        check_val("abort_en", en, 0);
        check_val("abort_rw", rw, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_in_ready", up_if.in_ready, 1);
        run_txn(4, 6, -1, 0, 0);

        // in_valid held across a whole transaction
        up_if.in_valid = 1'b1;
        up_if.a_val    = 5'd2;
        up_if.b_val    = 5'd3;
        acc_n = 0; acc2_c = -1; done_c = -1;
        for (int c = 0; c < 46; c++) begin
            #1;
            if (up_if.in_ready && up_if.in_valid) begin
                acc_n++;
                if (acc_n == 2) acc2_c = c;
            end
            if (done && done_c < 0) done_c = c;
            @(posedge clk);
            #1;
        end
        up_if.in_valid = 1'b0;
        check_val("held_valid_accepts", acc_n, 2);
        check_val("second_accept_cycle", acc2_c, 41);
        check_val("held_valid_done", done_c, 40);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check_val("final_done_seen", done, 1);
        tick();
        check_val("final_idle", up_if.in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
